// File: rtl/hazard_tag_pipeline.sv
// hazard_tag_pipeline
// Carries destination-register tags and write enables from ID through
// ID/EX, EX/MEM and MEM/WB for the forwarding unit. It also detects the
// hazards forwarding cannot cover (load-use and multi-cycle multiply
// occupancy of EX) and drives the stall/bubble controls for PC, IF/ID
// and ID/EX.
module hazard_tag_pipeline #(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ID_Valid,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_Uses_Rs,
    input  logic       ID_Uses_Rt,
    input  logic       ID_Wr,
    input  logic [4:0] ID_Rd,
    input  logic       ID_MemRead,
    input  logic       ID_Mul,
    input  logic       Branch_Taken,
    output logic       Stall_IF_ID,
    output logic       Bubble,
    output logic       Mul_Busy,
    output logic       IDEX_Wr,
    output logic       IDEX_MemRead,
    output logic       IDEX_Mul,
    output logic [4:0] IDEX_Rd,
    output logic       EXMEM_Wr,
    output logic [4:0] EXMEM_Rd,
    output logic       MEMWB_Wr,
    output logic [4:0] MEMWB_Rd
);

    // A multiply stalls the front end only when it needs more than one EX cycle.
    localparam logic       MUL_STALLS = (MUL_LAT > 32'd1);
    // Counter preload: BUSY runs from CNT_LOAD down to zero, i.e. MUL_LAT-1 cycles.
    localparam logic [3:0] CNT_LOAD   = (MUL_LAT > 32'd1) ? 4'(MUL_LAT - 32'd2) : 4'd0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_t;

    // Multiply occupancy FSM
    mul_state_t state_r;
    mul_state_t state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;

    // Hazard / control decisions
    logic       lu_s;
    logic       mul_busy_s;
    logic       stall_s;
    logic       bubble_s;

    // Tag stage registers
    logic       idex_wr_r;
    logic       idex_memread_r;
    logic       idex_mul_r;
    logic [4:0] idex_rd_r;
    logic       exmem_wr_r;
    logic [4:0] exmem_rd_r;
    logic       memwb_wr_r;
    logic [4:0] memwb_rd_r;

    // Next values of the tag stages
    logic       idex_wr_nxt_s;
    logic       idex_memread_nxt_s;
    logic       idex_mul_nxt_s;
    logic [4:0] idex_rd_nxt_s;
    logic       exmem_wr_nxt_s;
    logic [4:0] exmem_rd_nxt_s;
    logic       memwb_wr_nxt_s;
    logic [4:0] memwb_rd_nxt_s;

    // Load-use: a real ID instruction reads the non-zero register a load in EX is about to write.
    always_comb begin
        lu_s = 1'b0;
        if (ID_Valid && idex_memread_r && idex_wr_r && (idex_rd_r != 5'd0)) begin
            lu_s = (ID_Uses_Rs && (ID_Rs == idex_rd_r)) ||
                   (ID_Uses_Rt && (ID_Rt == idex_rd_r));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Multiply FSM next state and busy flag; busy excludes the multiply's final EX cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mul_busy_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (idex_mul_r && MUL_STALLS) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                    mul_busy_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                    mul_busy_s  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    // Final EX cycle: the multiply leaves ID/EX at the next edge.
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                    mul_busy_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = cnt_r - 4'd1;
                    mul_busy_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
                mul_busy_s  = 1'b0;
            end
        endcase
    end

    // Stage steering with priority multiply freeze > branch flush > load-use > normal advance.
    always_comb begin
        stall_s            = 1'b0;
        bubble_s           = 1'b0;
        idex_wr_nxt_s      = idex_wr_r;
        idex_memread_nxt_s = idex_memread_r;
        idex_mul_nxt_s     = idex_mul_r;
        idex_rd_nxt_s      = idex_rd_r;
        exmem_wr_nxt_s     = idex_wr_r;
        exmem_rd_nxt_s     = idex_rd_r;
        memwb_wr_nxt_s     = exmem_wr_r;
        memwb_rd_nxt_s     = exmem_rd_r;
        if (mul_busy_s) begin
            // Multiply holds EX: ID/EX keeps its tags, a bubble goes down to MEM.
            stall_s        = 1'b1;
            bubble_s       = 1'b0;
            exmem_wr_nxt_s = 1'b0;
            exmem_rd_nxt_s = 5'd0;
        end else if (Branch_Taken) begin
            // Flush the wrong-path instruction in ID; this also masks any load-use.
            stall_s            = 1'b0;
            bubble_s           = 1'b1;
            idex_wr_nxt_s      = 1'b0;
            idex_memread_nxt_s = 1'b0;
            idex_mul_nxt_s     = 1'b0;
            idex_rd_nxt_s      = 5'd0;
        end else if (lu_s) begin
            // Hold ID for one cycle; the load moves on to EX/MEM and becomes forwardable.
            stall_s            = 1'b1;
            bubble_s           = 1'b1;
            idex_wr_nxt_s      = 1'b0;
            idex_memread_nxt_s = 1'b0;
            idex_mul_nxt_s     = 1'b0;
            idex_rd_nxt_s      = 5'd0;
        end else begin
            // Normal advance; an invalid ID slot enters with all enables cleared.
            stall_s            = 1'b0;
            bubble_s           = 1'b0;
            idex_wr_nxt_s      = ID_Wr & ID_Valid;
            idex_memread_nxt_s = ID_MemRead & ID_Valid;
            idex_mul_nxt_s     = ID_Mul & ID_Valid;
            idex_rd_nxt_s      = ID_Rd;
        end
    end

    // Multiply FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Tag stage registers: ID/EX, EX/MEM, MEM/WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_wr_r      <= 1'b0;
            idex_memread_r <= 1'b0;
            idex_mul_r     <= 1'b0;
            idex_rd_r      <= 5'd0;
            exmem_wr_r     <= 1'b0;
            exmem_rd_r     <= 5'd0;
            memwb_wr_r     <= 1'b0;
            memwb_rd_r     <= 5'd0;
        end else begin
            idex_wr_r      <= idex_wr_nxt_s;
            idex_memread_r <= idex_memread_nxt_s;
            idex_mul_r     <= idex_mul_nxt_s;
            idex_rd_r      <= idex_rd_nxt_s;
            exmem_wr_r     <= exmem_wr_nxt_s;
            exmem_rd_r     <= exmem_rd_nxt_s;
            memwb_wr_r     <= memwb_wr_nxt_s;
            memwb_rd_r     <= memwb_rd_nxt_s;
        end
    end

    assign Stall_IF_ID  = stall_s;
    assign Bubble       = bubble_s;
    assign Mul_Busy     = mul_busy_s;
    assign IDEX_Wr      = idex_wr_r;
    assign IDEX_MemRead = idex_memread_r;
    assign IDEX_Mul     = idex_mul_r;
    assign IDEX_Rd      = idex_rd_r;
    assign EXMEM_Wr     = exmem_wr_r;
    assign EXMEM_Rd     = exmem_rd_r;
    assign MEMWB_Wr     = memwb_wr_r;
    assign MEMWB_Rd     = memwb_rd_r;

endmodule
